// File: rtl/hc_sr04_bin2bcd_pkg.sv
// Shared HC-SR04 definitions: range limit, distance width, BCD digit count
// and the one-hot state encoding used by the binary-to-BCD converter.
// Purely declarative; no logic, no latency, no backpressure.
package hc_sr04_bin2bcd_pkg;

  // Largest distance the sensor reports as valid, in cm.
  localparam int HC_MAX_RANGE = 400;
  // Width of the binary distance word.
  localparam int HC_DST_SZ    = $clog2(HC_MAX_RANGE);
  // BCD digits needed to hold HC_MAX_RANGE.
  localparam int HC_DIG_NUM   = 3;

  // One-hot so that any corrupted state is trivially detectable.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ADJ   = 4'b0010,
    ST_SHIFT = 4'b0100,
    ST_DONE  = 4'b1000
  } bcd_state_t;

  // Counter width able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hc_sr04_bin2bcd_if.sv
// Request/result bundle between the ranging FSM and the BCD converter.
// Latency and backpressure are defined by the converter; o_busy is the only stall indication.
// Ports: i_start/i_bin (request), o_bcd/o_done/o_busy/o_ovr (result/status).
interface hc_sr04_bin2bcd_if
  import hc_sr04_bin2bcd_pkg::*;
#(
  parameter int DST_SZ  = HC_DST_SZ,
  parameter int DIG_NUM = HC_DIG_NUM
) ();

  logic                   i_start;
  logic [DST_SZ-1:0]      i_bin;
  logic [4*DIG_NUM-1:0]   o_bcd;
  logic                   o_done;
  logic                   o_busy;
  logic                   o_ovr;

  // Requester side (ranging FSM / testbench).
  modport master (
    output i_start, i_bin,
    input  o_bcd, o_done, o_busy, o_ovr
  );

  // Converter side.
  modport slave (
    input  i_start, i_bin,
    output o_bcd, o_done, o_busy, o_ovr
  );

endinterface

// File: rtl/hc_sr04_bin2bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Purely combinational, zero latency, no backpressure.
// Ports: i_dig (4-bit digit in), o_dig (corrected digit out, wraps in 4 bits).
module hc_sr04_add3 (
  input  logic [3:0] i_dig,
  output logic [3:0] o_dig
);

  assign o_dig = (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;

endmodule

// File: rtl/hc_sr04_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per ADJ+SHIFT pair, MSB first.
// Latency: result and done pulse 2*DST_SZ+1 edges after the accepting edge.
// Backpressure: o_busy high while converting; starts seen outside IDLE are dropped, not queued.
// Ports: clk, rst_n (async active-low); bus = slave side of hc_sr04_bin2bcd_if.
module hc_sr04_bin2bcd
  import hc_sr04_bin2bcd_pkg::*;
#(
  parameter int MAX_RANGE = HC_MAX_RANGE,
  parameter int DST_SZ    = $clog2(MAX_RANGE),
  parameter int DIG_NUM   = HC_DIG_NUM
) (
  input  logic            clk,
  input  logic            rst_n,
  hc_sr04_bin2bcd_if.slave bus
);

  localparam int BCD_SZ = 4 * DIG_NUM;
  localparam int CNT_SZ = cnt_width(DST_SZ);

  localparam logic [DST_SZ-1:0] MAX_BIN  = DST_SZ'(MAX_RANGE);
  localparam logic [CNT_SZ-1:0] CNT_LOAD = CNT_SZ'(DST_SZ);
  localparam logic [CNT_SZ-1:0] CNT_ONE  = CNT_SZ'(1);

  bcd_state_t          r_state;
  bcd_state_t          w_state_nxt;

  logic [BCD_SZ-1:0]   r_scratch;
  logic [BCD_SZ-1:0]   w_scratch_adj;
  logic [DST_SZ-1:0]   r_bin;
  logic [CNT_SZ-1:0]   r_cnt;
  logic [BCD_SZ-1:0]   r_bcd;
  logic                r_done;
  logic                r_busy;
  logic                r_ovr;

  logic                w_over;
  logic                w_last;

  assign w_over = (bus.i_start == 1'b1) && (bus.i_bin > MAX_BIN);
  // The shift that consumes the final binary bit is the one that takes the counter to 0.
  assign w_last = (r_cnt == CNT_ONE);

  // One add-3 corrector per BCD digit.
  for (genvar g = 0; g < DIG_NUM; g++) begin : g_add3
    hc_sr04_add3 u_add3 (
      .i_dig (r_scratch[4*g +: 4]),
      .o_dig (w_scratch_adj[4*g +: 4])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; any non-one-hot value falls back to IDLE.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_state_nxt = bus.i_start ? ST_ADJ : ST_IDLE;
      ST_ADJ:   w_state_nxt = ST_SHIFT;
      ST_SHIFT: w_state_nxt = w_last ? ST_DONE : ST_ADJ;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scratch <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            // Out-of-range readings are clamped so the display shows the range limit.
            r_bin     <= w_over ? MAX_BIN : bus.i_bin;
            r_ovr     <= w_over;
            r_scratch <= '0;
            r_cnt     <= CNT_LOAD;
          end
        end
        ST_ADJ: begin
          r_scratch <= w_scratch_adj;
        end
        ST_SHIFT: begin
          {r_scratch, r_bin} <= {r_scratch[BCD_SZ-2:0], r_bin, 1'b0};
          r_cnt              <= r_cnt - CNT_ONE;
        end
        ST_DONE: begin
          r_bcd <= r_scratch;
        end
        default: begin
          // Corrupted state: drop the conversion in flight, keep the last result.
          r_scratch <= '0;
          r_bin     <= '0;
          r_cnt     <= '0;
        end
      endcase

      r_done <= (r_state == ST_DONE);
      // Tracks the state being entered so busy is high exactly in ADJ/SHIFT/DONE.
      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.o_bcd  = r_bcd;
  assign bus.o_done = r_done;
  assign bus.o_busy = r_busy;
  assign bus.o_ovr  = r_ovr;

endmodule

// File: doc/hc_sr04_bin2bcd.md
HC_SR04_BIN2BCD -- requirements
Module: hc_sr04_bin2bcd

Interface
REQ-001 Parameter MAX_RANGE, default 400: maximum valid distance in cm.
REQ-002 Parameter DST_SZ, default $clog2(MAX_RANGE) (9): binary distance width.
REQ-003 Parameter DIG_NUM, default 3: number of BCD digits; shall hold MAX_RANGE.
REQ-004 Clocking shall be one clock; reset shall be asynchronous and active-low.
REQ-005 CLK  in  1  clock, 50 MHz.
REQ-006 RST_n  in  1  asynchronous reset, active-low.
REQ-007 I_START  in  1  single-cycle conversion request (driven by the ranging FSM's conversion strobe).
REQ-008 I_BIN  in  DST_SZ  binary distance, valid in the I_START cycle.
REQ-009 O_BCD  out  4*DIG_NUM  packed BCD result; hundreds in the top nibble, units in the bottom nibble.
REQ-010 O_DONE  out  1  one-cycle pulse; O_BCD has just updated.
REQ-011 O_BUSY  out  1  conversion in progress.
REQ-012 O_OVR  out  1  last accepted I_BIN exceeded MAX_RANGE.

Function
REQ-013 Algorithm shall be sequential shift-add-3 (double dabble), processing one binary bit per ADJ+SHIFT pair, MSB first.
REQ-014 FSM states shall be one-hot IDLE, ADJ, SHIFT, DONE.
REQ-015 IDLE: when I_START=1, the block shall latch I_BIN (or MAX_RANGE if I_BIN>MAX_RANGE), latch O_OVR, clear the BCD scratch register, load the bit counter with DST_SZ, and go to ADJ.
REQ-016 ADJ: each scratch digit >=5 shall get +3 (4-bit, no carry out); next state is SHIFT.
REQ-017 SHIFT: {scratch, bin} shall shift left 1 and the bit counter shall decrement; if the counter reaches 0 the next state is DONE, otherwise ADJ.
REQ-018 DONE: O_BCD shall load from scratch, O_DONE shall be 1 for exactly one cycle, and the next state is IDLE.
REQ-019 Latency: O_BCD and O_DONE shall update on the same edge, 2*DST_SZ+1 rising edges after the edge that accepts I_START (19 for DST_SZ=9).
REQ-020 O_BUSY shall be 1 in ADJ, SHIFT and DONE, and 0 in IDLE.
REQ-021 I_START while O_BUSY=1 shall be ignored; there shall be no queuing and no effect on the current conversion.
REQ-022 I_START on the cycle DONE returns to IDLE shall be ignored; acceptance happens only in IDLE.
REQ-023 O_BCD and O_OVR shall hold their last value between conversions; the next accepted start updates O_OVR at acceptance and O_BCD at DONE.
REQ-024 Digit nibbles shall never hold values >9 at DONE for any I_BIN in 0..2^DST_SZ-1.
REQ-025 An illegal (non-one-hot) state shall return to IDLE on the next clock with scratch cleared; O_BCD shall hold its value.

Reset
REQ-026 RST_n=0 shall asynchronously force state IDLE and O_BCD=0, O_DONE=0, O_BUSY=0, O_OVR=0, with scratch, latched binary and counter all 0.
REQ-027 Reset asserted mid-conversion shall abort it: no O_DONE, and O_BCD=0 after release.
REQ-028 After RST_n deasserts, the first I_START shall be accepted on the next rising edge.

Structure
REQ-029 MAX_RANGE, DST_SZ derivation, DIG_NUM and the state encodings shall live in the shared HC-SR04 definitions package/include used by the ranging FSM.
REQ-030 One sub-module, hc_sr04_add3 (4-bit combinational: in>=5 ? in+3 : in), shall be instantiated once per digit.
REQ-031 All outputs shall be registered; no combinational path shall run from inputs to outputs.

Verification
REQ-032 Pulse I_START with I_BIN=400 -> exactly 19 clocks later O_DONE=1, O_BCD=0x400, O_OVR=0.
REQ-033 Pulse I_START with I_BIN=0 -> O_BCD=0x000; then I_BIN=58 -> O_BCD=0x058.
REQ-034 Pulse I_START with I_BIN=511 -> O_BCD=0x400, O_OVR=1; then I_BIN=123 -> O_BCD=0x123, O_OVR=0.
REQ-035 Pulse I_START with I_BIN=123, then pulse I_START with I_BIN=77 five clocks later -> a single O_DONE with O_BCD=0x123; the second request is ignored.
REQ-036 Pulse I_START with I_BIN=399, assert RST_n=0 at clock 8 -> no O_DONE, all outputs 0; after release, I_BIN=399 -> O_BCD=0x399.
REQ-037 Sweep I_BIN 0..511 back-to-back -> O_BCD equals the decimal value of min(I_BIN,400) and every nibble is <=9.
